// File: rtl/spi_sched_arbiter.sv
// spi_sched_arbiter: round-robin sharing of one SPI pad set among
// NREQ requesters, one mode-0 MSB-first byte per grant.

module spi_sched_arbiter #(
    parameter int NREQ    = 4,
    parameter int CLK_DIV = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [3*NREQ-1:0] req_ss_i,
    input  logic [8*NREQ-1:0] req_data_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic              done_o,
    output logic [2:0]        done_id_o,
    output logic [7:0]        rx_data_o,
    output logic              busy_o,
    output logic [7:0]        ss_pad_o,
    output logic              sclk_pad_o,
    output logic              mosi_pad_o,
    input  logic              miso_pad_i
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    half_q, half_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    win_q, win_d;
    logic [2:0]    ss_q, ss_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    rxo_q, rxo_d;
    logic [2:0]    id_q, id_d;

    logic          div_last;
    logic          found;
    logic [2:0]    win_c;
    logic [3:0]    ptr_nxt;
    int            arb_idx;

    assign div_last = (div_q == DW'(CLK_DIV - 1));
    assign ptr_nxt  = {1'b0, win_c} + 4'd1;

    // Winner = first pending request at or above the pointer, wrapping
    always_comb begin
        found   = 1'b0;
        win_c   = ptr_q;
        arb_idx = 0;
        for (int i = 0; i < NREQ; i++) begin
            arb_idx = int'(ptr_q) + i;
            if (arb_idx >= NREQ) begin
                arb_idx = arb_idx - NREQ;
            end
            if (!found && ((req_i & (NREQ'(1) << arb_idx)) != '0)) begin
                found = 1'b1;
                win_c = 3'(arb_idx);
            end
        end
    end

    // Transfer sequencer: phase timing, shift registers, RR pointer
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        half_d  = half_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        ss_d    = ss_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rxo_d   = rxo_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                div_d  = '0;
                half_d = '0;
                if (found) begin
                    state_d = SETUP;
                    win_d   = win_c;
                    ss_d    = 3'(req_ss_i >> (3 * int'(win_c)));
                    tx_d    = 8'(req_data_i >> (8 * int'(win_c)));
                    ptr_d   = (ptr_nxt == 4'(NREQ)) ? 3'd0 : ptr_nxt[2:0];
                end
            end
            SETUP: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = SHIFT;
                    rx_d    = {rx_q[6:0], miso_pad_i};
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            SHIFT: begin
                if (div_last) begin
                    div_d  = '0;
                    half_d = half_q + 4'd1;
                    if (half_q == 4'd15) begin
                        state_d = HOLD;
                    end else if (half_q[0]) begin
                        rx_d = {rx_q[6:0], miso_pad_i};
                    end else if (half_q != 4'd14) begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            HOLD: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = GAP;
                    rxo_d   = rx_q;
                    id_d    = win_q;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            GAP: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pad and handshake outputs decoded from registered state
    always_comb begin
        gnt_o    = '0;
        ss_pad_o = 8'hFF;
        if (state_q == SETUP && div_q == '0) begin
            gnt_o = NREQ'(1) << win_q;
        end
        if (state_q inside {SETUP, SHIFT, HOLD}) begin
            ss_pad_o = ~(8'd1 << ss_q);
        end
    end

    assign sclk_pad_o = (state_q == SHIFT) && !half_q[0];
    assign mosi_pad_o = tx_q[7];
    assign done_o     = (state_q == GAP) && (div_q == '0);
    assign busy_o     = (state_q != IDLE);
    assign done_id_o  = id_q;
    assign rx_data_o  = rxo_q;

    // State registers with synchronous active-low reset
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            half_q  <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            ss_q    <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            rxo_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            ss_q    <= ss_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            rxo_q   <= rxo_d;
            id_q    <= id_d;
        end
    end

endmodule

// File: doc/spi_sched_arbiter.md
# spi_sched_arbiter

Round-robin scheduler that shares the SPI pad interface (`ss_pad_o`, `sclk_pad_o`, `mosi_pad_o`, `miso_pad_i`) among NREQ on-chip requesters.

- Each request is one 8-bit, mode-0, MSB-first full-duplex transfer to one of 8 slaves.
- The block arbitrates requests, sequences slave-select setup, shift, hold and gap, generates SCLK from the system clock, and returns the received byte to the winning requester.
- It sits between internal masters and the `io_intf` pad bundle that the slave agents drive and monitor.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `CLK_DIV`, 2: SCLK half-period in `wb_clk_i` cycles (≥1).

Ports:
- `wb_clk_i` in 1: system clock; the only clock.
- `wb_rst_n_i` in 1: reset, synchronous, active-low.
- `req_i` in NREQ: request level per requester; held high until granted.
- `req_ss_i` in 3*NREQ: slave index per requester (slot k = bits 3k+2:3k).
- `req_data_i` in 8*NREQ: TX byte per requester (slot k = bits 8k+7:8k).
- `gnt_o` out NREQ: one-cycle one-hot grant pulse.
- `done_o` out 1: one-cycle pulse when the transfer completes.
- `done_id_o` out 3: requester index of the completed transfer; valid with `done_o`.
- `rx_data_o` out 8: received byte; valid with `done_o` and held until the next `done_o`.
- `busy_o` out 1: high in every non-IDLE state.
- `ss_pad_o` out 8: slave selects, active-low.
- `sclk_pad_o` out 1: serial clock; idles low.
- `mosi_pad_o` out 1: serial data out.
- `miso_pad_i` in 1: serial data in.

## Operation
- **Reset values:** `ss_pad_o`=8'hFF, `sclk_pad_o`=0, `mosi_pad_o`=0, `gnt_o`=0, `done_o`=0, `done_id_o`=0, `rx_data_o`=0, `busy_o`=0, state=IDLE, RR pointer=0.
- **States:** IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- **IDLE:**
  - If any `req_i` bit is high, select a winner w as the first set bit searching upward from the pointer, wrapping modulo NREQ.
  - On that edge, latch `req_ss_i[w]`, `req_data_i[w]` and w. Set pointer = (w+1) mod NREQ.
  - Go to SETUP.
- **SETUP (CLK_DIV cycles):**
  - `gnt_o[w]` is high on the first SETUP cycle only.
  - `ss_pad_o[ss]`=0; all other bits stay 1.
  - `mosi_pad_o` = TX bit 7; `sclk_pad_o`=0.
- **SHIFT (16·CLK_DIV cycles):** 16 half-periods, alternating SCLK high and low, starting high.
  - On each rising SCLK (entry into a high half-period), sample `miso_pad_i` into the RX shift register LSB, shifting left.
  - On each falling SCLK except the last, shift TX left; `mosi_pad_o` presents the next bit.
  - Exactly 8 rising edges occur.
- **HOLD (CLK_DIV cycles):** `sclk_pad_o`=0; SS stays asserted; `mosi_pad_o` holds bit 0.
- **GAP (CLK_DIV cycles):**
  - `ss_pad_o`=8'hFF from the first GAP cycle.
  - `done_o`=1 on the first GAP cycle only, with `rx_data_o`=RX register and `done_id_o`=w.
  - Requests are ignored until IDLE.
- The requester must drop `req_i` in the cycle after it sees its `gnt_o`. A request still high in IDLE is treated as a new transfer.
- Requests are not accepted while `busy_o`=1. Data on non-winning slots is ignored.

## Timing
- Arbitration edge = cycle 0; `gnt_o` and SS assertion occur in cycle 1.
- First SCLK rise: cycle 1+CLK_DIV.
- SS low for 18·CLK_DIV cycles.
- `done_o` at cycle 1+18·CLK_DIV.
- Back-to-back transfers: next arbitration edge at cycle 1+19·CLK_DIV. The next grant follows one cycle after that edge.
- Cycle counts are fixed, with no dependence on data.
- `mosi_pad_o` changes only on falling-SCLK cycles or on SETUP entry. This gives ≥CLK_DIV cycles of setup before each rising edge and satisfies the monitor's input skew.
- Simultaneous requests: exactly one grant per transfer, in RR order.
- A `req_i` that rises in the same cycle the block returns to IDLE is eligible on that edge.
- Reset asserted mid-transfer:
  - Takes effect at the next edge; all outputs return to reset values.
  - No `done_o` or `gnt_o` pulses for the aborted transfer.
  - RR pointer returns to 0.
- `rx_data_o` is registered; it never changes outside a `done_o` cycle.

## Test plan
- **Single transfer.** Setup: NREQ=4, CLK_DIV=2, req_i=4'b0010, req_ss_i slot1=3, data 8'hA5; slave model returns 8'h3C.
  - `gnt_o`=4'b0010 for one cycle.
  - `ss_pad_o`=8'hF7 for 36 cycles.
  - MOSI sampled on the 8 rises is 1,0,1,0,0,1,0,1.
  - `done_o` with `rx_data_o`=8'h3C and `done_id_o`=1.
- **Round-robin order.** Setup: all four req_i high continuously, each dropping after its grant and re-asserting after its `done_o`.
  - Grant order 0,1,2,3,0.
  - 39 cycles between successive grants.
- **Pointer wrap.** Setup: after a grant to 3, req_i=4'b1001.
  - Next grant goes to 0, then 3.
- **Minimum divider.** Setup: CLK_DIV=1, data 8'hFF, MISO tied 0.
  - SCLK toggles every cycle, with 8 rising edges.
  - `rx_data_o`=8'h00.
  - SS low for 18 cycles.
- **Reset mid-shift.** Setup: reset pulsed low for 1 cycle after the 4th SCLK rise.
  - Next cycle: `ss_pad_o`=8'hFF, SCLK=0, `busy_o`=0.
  - No `done_o`.
  - A subsequent request from requester 2 is granted first (pointer=0 search).
- **Request during busy.** Setup: req_i[1] rises during SHIFT of requester 0.
  - No grant until IDLE.
  - Grant to 1 exactly one cycle after the first arbitration edge following GAP.
